// File: rtl/charbuf_cmd_sched_if.sv
// Console-side command port of the character-buffer scheduler.
// A command transfers on a cycle where cmd_valid and cmd_ready are both high; fields are sampled only then.
interface charbuf_cmd_sched_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_op;
  logic [4:0] cmd_row;
  logic [6:0] cmd_col;
  logic [6:0] cmd_data;

  modport master (output cmd_valid, cmd_op, cmd_row, cmd_col, cmd_data, input cmd_ready);
  modport slave  (input cmd_valid, cmd_op, cmd_row, cmd_col, cmd_data, output cmd_ready);
endinterface

// File: rtl/charbuf_cmd_sched.sv
// Owns port B of the 80x32 character buffer: direct writes, scroll copy, and
// clear/erase sequenced through the init engine with its write stream forwarded.
module charbuf_cmd_sched #(
  parameter int COLS         = 80,
  parameter int ROWS         = 32,
  parameter int INIT_TIMEOUT = 7
) (
  input  logic                clk,
  input  logic                resetn,
  charbuf_cmd_sched_if.slave  cmd,
  output logic                busy,
  output logic                err,
  output logic                init_enable,
  output logic                init_part_line,
  output logic [4:0]          init_part_row,
  output logic [6:0]          init_part_col,
  output logic                init_seq,
  input  logic                init_wr_en,
  input  logic [11:0]         init_addr,
  input  logic [6:0]          init_data,
  output logic                ram_we,
  output logic [11:0]         ram_addr,
  output logic [6:0]          ram_wdata,
  input  logic [6:0]          ram_rd_data,
  output logic [2:0]          dbg_state_o
);

  localparam logic [1:0] OP_WRITE  = 2'd0;
  localparam logic [1:0] OP_CLEAR  = 2'd1;
  localparam logic [1:0] OP_ERASE  = 2'd2;
  localparam logic [6:0] COL_LIM   = 7'(COLS);
  localparam logic [6:0] COL_LAST  = 7'(COLS - 1);
  localparam logic [4:0] ROW_LAST  = 5'(ROWS - 1);
  localparam logic [3:0] TMO       = 4'(INIT_TIMEOUT);

  typedef enum logic [2:0] {
    IDLE, WR, PULSE_HI, PULSE_LO, INIT_WAIT, INIT_RUN, SC_RD, SC_WR
  } state_t;

  state_t     state_q, state_d;
  logic [4:0] row_q, row_d;
  logic [6:0] col_q, col_d;
  logic [6:0] data_q, data_d;
  logic       part_q, part_d;
  logic [3:0] tmo_q, tmo_d;
  logic       err_q, err_d;
  logic       wr_prev_q;

  logic        we_c, en_c;
  logic [11:0] addr_c;
  logic [6:0]  wdata_c;
  logic        idle, in_init, part_act;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q   <= IDLE;
      row_q     <= '0;
      col_q     <= '0;
      data_q    <= '0;
      part_q    <= 1'b0;
      tmo_q     <= '0;
      err_q     <= 1'b0;
      wr_prev_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      row_q     <= row_d;
      col_q     <= col_d;
      data_q    <= data_d;
      part_q    <= part_d;
      tmo_q     <= tmo_d;
      err_q     <= err_d;
      wr_prev_q <= init_wr_en;
    end
  end

  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    col_d   = col_q;
    data_d  = data_q;
    part_d  = part_q;
    tmo_d   = tmo_q;
    err_d   = 1'b0;
    we_c    = 1'b0;
    en_c    = 1'b0;
    addr_c  = '0;
    wdata_c = '0;
    unique case (state_q)
      IDLE: begin
        // A stray engine write enable outside a clear/erase is reported once per rising edge.
        if (init_wr_en && !wr_prev_q) err_d = 1'b1;
        if (cmd.cmd_valid) begin
          case (cmd.cmd_op)
            OP_WRITE, OP_ERASE: begin
              if (cmd.cmd_col >= COL_LIM) begin
                err_d = 1'b1;
              end else begin
                row_d   = cmd.cmd_row;
                col_d   = cmd.cmd_col;
                data_d  = cmd.cmd_data;
                part_d  = (cmd.cmd_op == OP_ERASE);
                tmo_d   = 4'd1;
                state_d = (cmd.cmd_op == OP_WRITE) ? WR : PULSE_HI;
              end
            end
            OP_CLEAR: begin
              part_d  = 1'b0;
              tmo_d   = 4'd1;
              state_d = PULSE_HI;
            end
            default: begin
              row_d   = 5'd1;
              col_d   = '0;
              part_d  = 1'b0;
              state_d = SC_RD;
            end
          endcase
        end
      end
      WR: begin
        we_c    = 1'b1;
        addr_c  = {col_q, row_q};
        wdata_c = data_q;
        state_d = IDLE;
      end
      PULSE_HI: begin
        en_c    = 1'b1;
        tmo_d   = tmo_q + 4'd1;
        state_d = PULSE_LO;
      end
      PULSE_LO: begin
        tmo_d   = tmo_q + 4'd1;
        state_d = INIT_WAIT;
      end
      INIT_WAIT, INIT_RUN: begin
        we_c    = init_wr_en;
        addr_c  = init_addr;
        wdata_c = init_data;
        if (state_q == INIT_RUN) begin
          if (!init_wr_en) state_d = IDLE;
        end else if (init_wr_en) begin
          state_d = INIT_RUN;
        end else if (tmo_q >= TMO) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end else begin
          tmo_d = tmo_q + 4'd1;
        end
      end
      SC_RD: begin
        addr_c  = {col_q, row_q};
        state_d = SC_WR;
      end
      SC_WR: begin
        we_c    = 1'b1;
        addr_c  = {col_q, row_q - 5'd1};
        wdata_c = ram_rd_data;
        state_d = SC_RD;
        if (col_q == COL_LAST) begin
          col_d = '0;
          // Copy done: row_q already holds the last row, erase it from column 0.
          if (row_q == ROW_LAST) begin
            part_d  = 1'b1;
            tmo_d   = 4'd1;
            state_d = PULSE_HI;
          end else begin
            row_d = row_q + 5'd1;
          end
        end else begin
          col_d = col_q + 7'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign idle     = (state_q == IDLE);
  assign in_init  = (state_q == PULSE_HI) || (state_q == PULSE_LO) ||
                    (state_q == INIT_WAIT) || (state_q == INIT_RUN);
  assign part_act = in_init && part_q;

  assign cmd.cmd_ready  = resetn && idle;
  assign busy           = resetn && !idle;
  assign err            = err_q;
  assign init_enable    = resetn && en_c;
  assign init_part_line = part_act;
  assign init_part_row  = part_act ? row_q : '0;
  assign init_part_col  = part_act ? col_q : '0;
  assign init_seq       = 1'b0;
  assign ram_we         = resetn && we_c;
  assign ram_addr       = addr_c;
  assign ram_wdata      = wdata_c;
  assign dbg_state_o    = state_q;

endmodule

// File: tb/tb_charbuf_cmd_sched.sv
// Directed bench for charbuf_cmd_sched with a behavioural init engine and port-B RAM model.
module tb_charbuf_cmd_sched;

  logic        clk = 1'b0;
  logic        resetn;
  logic        busy, err, init_enable, init_part_line, init_seq;
  logic [4:0]  init_part_row;
  logic [6:0]  init_part_col;
  logic        init_wr_en;
  logic [11:0] init_addr;
  logic [6:0]  init_data;
  logic        ram_we;
  logic [11:0] ram_addr;
  logic [6:0]  ram_wdata;
  logic [6:0]  ram_rd_data;
  logic [2:0]  dbg_state;

  charbuf_cmd_sched_if cif();

  charbuf_cmd_sched dut (
    .clk(clk), .resetn(resetn), .cmd(cif),
    .busy(busy), .err(err), .init_enable(init_enable),
    .init_part_line(init_part_line), .init_part_row(init_part_row),
    .init_part_col(init_part_col), .init_seq(init_seq),
    .init_wr_en(init_wr_en), .init_addr(init_addr), .init_data(init_data),
    .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_rd_data(ram_rd_data), .dbg_state_o(dbg_state)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- RAM model ----------------
  logic [6:0] mem [0:4095];
  logic       preload_req;

  function automatic logic [6:0] pat(input int r, input int c);
    return 7'((r * 3 + c) & 127);
  endfunction

  function automatic logic [11:0] adr(input int c, input int r);
    return {7'(c), 5'(r)};
  endfunction

  always @(posedge clk) begin
    if (preload_req) begin
      for (int i = 0; i < 4096; i++) mem[i] <= pat(i % 32, i / 32);
    end else if (ram_we) begin
      mem[ram_addr] <= ram_wdata;
    end
    ram_rd_data <= mem[ram_addr];
  end

  // ---------------- init engine model ----------------
  logic        eng_on, eng_act, en_prev, e_part, spur;
  logic [11:0] e_addr;

  always @(posedge clk) begin
    if (!resetn) begin
      eng_act <= 1'b0; en_prev <= 1'b0; e_part <= 1'b0; e_addr <= '0;
    end else begin
      en_prev <= init_enable;
      if (!eng_act) begin
        if (en_prev && !init_enable && eng_on) begin
          eng_act <= 1'b1;
          e_part  <= init_part_line;
          e_addr  <= init_part_line ? {init_part_col, init_part_row} : 12'h000;
        end
      end else if (e_part ? (e_addr[11:5] == 7'd79) : (e_addr == 12'h9FF)) begin
        eng_act <= 1'b0;
      end else begin
        e_addr <= e_part ? e_addr + 12'd32 : e_addr + 12'd1;
      end
    end
  end

  assign init_wr_en = eng_act | spur;
  assign init_addr  = e_addr;
  assign init_data  = 7'd0;

  // ---------------- scoreboard ----------------
  logic [18:0] exp_q[$];
  int          exp_err;
  int          n_checks, n_fail;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  task automatic monitor();
    logic [18:0] w;
    forever begin
      @(negedge clk);
      if (ram_we === 1'b1) begin
        if (exp_q.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL unexpected_write: got addr=0x%0h data=0x%0h, required no write", ram_addr, ram_wdata);
        end else begin
          w = exp_q.pop_front();
          check("ram_write", 32'({ram_addr, ram_wdata}), 32'(w));
        end
      end
      if (err === 1'b1) begin
        n_checks++;
        if (exp_err == 0) begin
          n_fail++;
          $display("FAIL unexpected_err: got err=1, required err=0");
        end else begin
          exp_err--;
        end
      end
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic settle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic preload();
    @(negedge clk); preload_req = 1'b1;
    @(negedge clk); preload_req = 1'b0;
  endtask

  task automatic issue(input logic [1:0] op, input logic [4:0] row, input logic [6:0] col, input logic [6:0] data);
    int w;
    w = 0;
    @(negedge clk);
    while (!cif.cmd_ready && w < 100) begin @(negedge clk); w++; end
    if (w >= 100) begin
      n_checks++; n_fail++;
      $display("FAIL cmd_ready_wait: got cmd_ready=0 for 100 cycles, required 1");
    end
    cif.cmd_valid = 1'b1; cif.cmd_op = op; cif.cmd_row = row; cif.cmd_col = col; cif.cmd_data = data;
    @(posedge clk); #1;
    cif.cmd_valid = 1'b0; cif.cmd_row = 5'h1F; cif.cmd_col = 7'h7F; cif.cmd_data = 7'h00;
  endtask

  task automatic wait_idle(input logic chk_part, input logic pline, input logic [4:0] prow,
                           input logic [6:0] pcol, output int cyc, output int en_cnt, output int part_bad);
    cyc = 0; en_cnt = 0; part_bad = 0;
    while (1) begin
      @(negedge clk);
      if (!busy) break;
      cyc++;
      if (init_enable) en_cnt++;
      if (chk_part && (init_part_line !== pline || init_part_row !== prow || init_part_col !== pcol))
        part_bad++;
      if (cyc >= 20000) begin
        n_checks++; n_fail++;
        $display("FAIL busy_timeout: got busy after %0d cycles, required idle", cyc);
        break;
      end
    end
  endtask

  task automatic push_scroll();
    for (int r = 1; r < 32; r++)
      for (int c = 0; c < 80; c++) exp_q.push_back({adr(c, r - 1), pat(r, c)});
    for (int c = 0; c < 80; c++) exp_q.push_back({adr(c, 31), 7'd0});
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int cyc, en_cnt, part_bad, bad;
    n_checks = 0; n_fail = 0; exp_err = 0;
    resetn = 1'b0; eng_on = 1'b1; spur = 1'b0; preload_req = 1'b0;
    cif.cmd_valid = 1'b0; cif.cmd_op = 2'd0; cif.cmd_row = '0; cif.cmd_col = '0; cif.cmd_data = '0;
    fork monitor(); join_none

    repeat (3) @(negedge clk);
    check("rst_cmd_ready", 32'(cif.cmd_ready), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_ram_we", 32'(ram_we), 32'd0);
    check("rst_init_enable", 32'(init_enable), 32'd0);
    resetn = 1'b1;
    @(negedge clk);
    check("idle_cmd_ready", 32'(cif.cmd_ready), 32'd1);
    check("idle_state", 32'(dbg_state), 32'd0);
    check("idle_err", 32'(err), 32'd0);
    check("init_seq", 32'(init_seq), 32'd0);

    // WRITE row 3 col 10 -> {10,3} = 0x143
    exp_q.push_back({12'h143, 7'h41});
    issue(2'd0, 5'd3, 7'd10, 7'h41);
    wait_idle(1'b0, 1'b0, 5'd0, 7'd0, cyc, en_cnt, part_bad);
    check("write_busy_cycles", 32'(cyc), 32'd1);
    check("write_ready_back", 32'(cif.cmd_ready), 32'd1);

    // Out-of-range column on WRITE and ERASE_LINE
    exp_err++;
    issue(2'd0, 5'd0, 7'd80, 7'h55);
    wait_idle(1'b0, 1'b0, 5'd0, 7'd0, cyc, en_cnt, part_bad);
    check("badwrite_busy_cycles", 32'(cyc), 32'd0);
    exp_err++;
    issue(2'd2, 5'd2, 7'd80, 7'h00);
    wait_idle(1'b0, 1'b0, 5'd0, 7'd0, cyc, en_cnt, part_bad);
    check("baderase_busy_cycles", 32'(cyc), 32'd0);
    settle(2);
    check("bad_col_err_count", 32'(exp_err), 32'd0);

    // Last valid cell {79,31} = 0x9FF
    exp_q.push_back({12'h9FF, 7'h7F});
    issue(2'd0, 5'd31, 7'd79, 7'h7F);
    wait_idle(1'b0, 1'b0, 5'd0, 7'd0, cyc, en_cnt, part_bad);
    check("lastcell_busy_cycles", 32'(cyc), 32'd1);

    // Stray engine write enables while idle: two rising edges, two errors, no writes
    settle(1);
    exp_err += 2;
    spur = 1'b1; settle(3); spur = 1'b0; settle(2);
    spur = 1'b1; settle(1); spur = 1'b0; settle(3);
    check("stray_wr_err_count", 32'(exp_err), 32'd0);
    check("stray_no_write", 32'(exp_q.size()), 32'd0);

    // CLEAR_SCREEN: 2560 writes + pulse hi/lo + exit cycle
    preload();
    for (int a = 0; a < 2560; a++) exp_q.push_back({12'(a), 7'd0});
    issue(2'd1, 5'd0, 7'd0, 7'd0);
    wait_idle(1'b1, 1'b0, 5'd0, 7'd0, cyc, en_cnt, part_bad);
    check("clear_busy_cycles", 32'(cyc), 32'd2563);
    check("clear_enable_cycles", 32'(en_cnt), 32'd1);
    check("clear_part_line_low", 32'(part_bad), 32'd0);
    check("clear_ready_back", 32'(cif.cmd_ready), 32'd1);
    settle(2);
    check("clear_writes_done", 32'(exp_q.size()), 32'd0);
    bad = 0;
    for (int c = 0; c < 80; c++) for (int r = 0; r < 32; r++) if (mem[adr(c, r)] !== 7'd0) bad++;
    check("clear_ram_zero", 32'(bad), 32'd0);

    // ERASE_LINE row 5 from col 70: cols 70..79
    preload();
    for (int c = 70; c < 80; c++) exp_q.push_back({adr(c, 5), 7'd0});
    issue(2'd2, 5'd5, 7'd70, 7'd0);
    wait_idle(1'b1, 1'b1, 5'd5, 7'd70, cyc, en_cnt, part_bad);
    check("erase_busy_cycles", 32'(cyc), 32'd13);
    check("erase_enable_cycles", 32'(en_cnt), 32'd1);
    check("erase_part_held", 32'(part_bad), 32'd0);
    settle(2);
    check("erase_writes_done", 32'(exp_q.size()), 32'd0);
    bad = 0;
    for (int c = 0; c < 80; c++) for (int r = 0; r < 32; r++)
      if (mem[adr(c, r)] !== ((r == 5 && c >= 70) ? 7'd0 : pat(r, c))) bad++;
    check("erase_ram_content", 32'(bad), 32'd0);

    // SCROLL_UP: 4960 copy cycles + 83 erase cycles for row 31
    preload();
    push_scroll();
    issue(2'd3, 5'd0, 7'd0, 7'd0);
    wait_idle(1'b0, 1'b0, 5'd0, 7'd0, cyc, en_cnt, part_bad);
    check("scroll_busy_cycles", 32'(cyc), 32'd5043);
    check("scroll_enable_cycles", 32'(en_cnt), 32'd1);
    settle(2);
    check("scroll_writes_done", 32'(exp_q.size()), 32'd0);
    bad = 0;
    for (int c = 0; c < 80; c++) for (int r = 0; r < 32; r++)
      if (mem[adr(c, r)] !== ((r == 31) ? 7'd0 : pat(r + 1, c))) bad++;
    check("scroll_ram_content", 32'(bad), 32'd0);

    // CLEAR_SCREEN with the engine held idle: times out 7 cycles after PULSE_HI
    eng_on = 1'b0;
    exp_err++;
    issue(2'd1, 5'd0, 7'd0, 7'd0);
    wait_idle(1'b1, 1'b0, 5'd0, 7'd0, cyc, en_cnt, part_bad);
    check("timeout_busy_cycles", 32'(cyc), 32'd7);
    check("timeout_enable_cycles", 32'(en_cnt), 32'd1);
    settle(2);
    check("timeout_err_count", 32'(exp_err), 32'd0);
    check("timeout_init_dropped", 32'({init_enable, init_part_line}), 32'd0);
    eng_on = 1'b1;

    // Reset in the middle of a scroll: no writes from the reset cycle on
    preload();
    push_scroll();
    issue(2'd3, 5'd0, 7'd0, 7'd0);
    settle(100);
    check("midscroll_busy", 32'(busy), 32'd1);
    @(posedge clk); #2;
    exp_q.delete();
    resetn = 1'b0;
    #1;
    check("midscroll_rst_we", 32'(ram_we), 32'd0);
    settle(1);
    check("midscroll_rst_we_next", 32'(ram_we), 32'd0);
    settle(2);
    resetn = 1'b1;
    @(negedge clk);
    check("postrst_cmd_ready", 32'(cif.cmd_ready), 32'd1);
    check("postrst_state", 32'(dbg_state), 32'd0);
    exp_q.push_back({12'h000, 7'h2A});
    issue(2'd0, 5'd0, 7'd0, 7'h2A);
    wait_idle(1'b0, 1'b0, 5'd0, 7'd0, cyc, en_cnt, part_bad);
    check("postrst_write_cycles", 32'(cyc), 32'd1);

    settle(3);
    check("final_write_queue", 32'(exp_q.size()), 32'd0);
    check("final_err_queue", 32'(exp_err), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/charbuf_cmd_sched.md
Name: charbuf_cmd_sched

Overview:
- Command scheduler that owns write/read port B of the 80x32 character buffer RAM. Port A is the VGA display read port and is not touched here.
- Accepts console-side commands (write char, clear screen, erase line, scroll up) and executes them in one of two ways:
  - drives port B directly, or
  - sequences the character-buffer init/clear engine (enable fall-edge start, partial-line mode) and forwards its write stream to the RAM.
- Sits between the terminal/console logic and the character buffer.

Parameters:
- COLS, 80, characters per row; valid columns are 0..COLS-1.
- ROWS, 32, rows; row field is 5 bits.
- INIT_TIMEOUT, 7, cycles allowed after the start pulse for the init engine to assert its write enable.

Ports:
- clk  in  1  clock
- resetn  in  1  reset, synchronous, active-low
- cmd_valid  in  1  command request
- cmd_ready  out  1  scheduler idle, can accept a command
- cmd_op  in  2  0=WRITE, 1=CLEAR_SCREEN, 2=ERASE_LINE, 3=SCROLL_UP
- cmd_row  in  5  target row (WRITE, ERASE_LINE)
- cmd_col  in  7  target column (WRITE), start column (ERASE_LINE)
- cmd_data  in  7  character code (WRITE)
- busy  out  1  a command is executing
- err  out  1  one-cycle pulse on a rejected or failed command
- init_enable  out  1  start pulse to the init engine (engine acts on the falling edge)
- init_part_line  out  1  partial-line mode request to the init engine
- init_part_row  out  5  row for a partial-line erase
- init_part_col  out  7  start column for a partial-line erase
- init_seq  out  1  sequential-fill request; always 0
- init_wr_en  in  1  init engine write enable
- init_addr  in  12  init engine address {col,row}
- init_data  in  7  init engine data
- ram_we  out  1  port B write enable
- ram_addr  out  12  port B address {col[6:0],row[4:0]}
- ram_wdata  out  7  port B write data
- ram_rd_data  in  7  port B read data, 1-cycle latency from ram_addr

Behaviour:
Reset:
- All outputs are 0 and the state is IDLE.
- Reset mid-command aborts immediately with no further RAM writes. The init engine shares resetn.

Handshake:
- cmd_ready = (state==IDLE). A command is accepted on cmd_valid & cmd_ready.
- Fields are latched on acceptance; cmd_* may change afterwards.
- busy = ~cmd_ready.

States: IDLE, WR, PULSE_HI, PULSE_LO, INIT_WAIT, INIT_RUN, SC_RD, SC_WR.

WRITE:
- If cmd_col >= COLS: accepted, err pulses on the cycle after acceptance, no write, stay IDLE.
- Otherwise go to WR. In WR, ram_we=1 with ram_addr={col,row} and ram_wdata=data for exactly 1 cycle, then back to IDLE.
- Accept-to-write latency is 1 cycle. cmd_ready is low for 1 cycle.

CLEAR_SCREEN:
- PULSE_HI: init_enable=1 for 1 cycle.
- PULSE_LO: init_enable=0.
- INIT_WAIT: wait for init_wr_en=1.
- INIT_RUN: stay while init_wr_en=1; go to IDLE on the first cycle init_wr_en=0.
- init_part_line=0 throughout.

ERASE_LINE:
- Same sequence as CLEAR_SCREEN, with init_part_line=1 and init_part_row/col = latched row/col.
- These are held stable from PULSE_HI until INIT_RUN exits; the engine reloads them every idle cycle.
- If col >= COLS: err, no action.

INIT_WAIT timeout:
- If init_wr_en has not risen within INIT_TIMEOUT cycles of entering PULSE_HI: err pulse, return to IDLE, drop the init_* outputs.

Forwarding:
- In INIT_WAIT/INIT_RUN: ram_we=init_wr_en, ram_addr=init_addr, ram_wdata=init_data, passed through combinationally.
- In all other states init_wr_en is ignored. If it is high in IDLE, err pulses once per rising edge.

SCROLL_UP:
- Internal row counter r=1..ROWS-1 and column counter c=0..COLS-1.
- SC_RD: ram_addr={c,r}, ram_we=0.
- SC_WR: ram_we=1, ram_addr={c,r-1}, ram_wdata=ram_rd_data.
- Column c is incremented after each SC_WR. At c=COLS-1 it wraps to 0 and r increments.
- After the write at r=ROWS-1, c=COLS-1, run the ERASE_LINE sequence with row=ROWS-1, col=0.
- Copy phase is 2*(ROWS-1)*COLS = 4960 cycles. Row 0's old content is discarded.

Other rules:
- Commands are never queued or pre-empted. cmd_valid while busy is held off by cmd_ready=0.
- ram_we is never asserted from two sources in the same cycle.
- The {col,row} packing matches the init engine, so no address translation is needed.

Test Plan:
1. Reset, then WRITE row=3 col=10 data=0x41 -> next cycle ram_we=1, ram_addr=0x143, ram_wdata=0x41; busy high 1 cycle; cmd_ready back next cycle.
2. WRITE col=80 -> err pulse, no ram_we, cmd_ready stays effectively immediate.
3. CLEAR_SCREEN with behavioural init engine -> init_enable high 1 cycle, then 2560 forwarded writes, addresses 0x000..0x9FF with data 0; busy drops the cycle after init_wr_en falls; second command accepted then.
4. ERASE_LINE row=5 col=70 -> init_part_line/row/col held; 10 writes to cols 70..79 of row 5; no other addresses touched.
5. SCROLL_UP with preloaded pattern data=(row*3+col)&0x7F -> rows 0..30 contain old rows 1..31; row 31 all 0; total busy = 4960 + erase cycles.
6. CLEAR_SCREEN with init engine held idle -> err after INIT_TIMEOUT cycles, return to IDLE; also assert resetn low mid-scroll -> ram_we=0 next cycle, cmd_ready=1 after release.
